regfile_mp: RTL and testbench

Parametrised register file: the next-generation architectural register store for the CPU datapath. Provides two asynchronous read ports and one synchronous write port with optional same-cycle write-to-read bypass, a per-register pending (scoreboard) bit for hazard detection, and a sequenced post-reset clear. Sits between decode (read/reserve) and writeback (write).

---
 rtl/regfile_mp.sv | 141 ++++++++++++++
 tb/tb_regfile_mp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported architectural register file: two async read ports, one write port, pending scoreboard,
// sequenced post-reset clear. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              ready,
    output logic              wr_orphan
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_W-1:0]       clr_cnt_r;
    logic [DATA_W-1:0]       mem_r [DEPTH];
    logic [DEPTH-1:0]        pending_r;
    logic                    orphan_r;
    logic                    run_s;
    logic                    wr_acc_s;
    logic                    rsv_acc_s;
    logic [1:0][ADDR_W-1:0]  rd_addr_s;
    logic [1:0][DATA_W-1:0]  rd_data_s;
    logic [1:0]              busy_s;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == {ADDR_W{1'b0}});
    endfunction

    assign run_s     = (state_r == ST_RUN);
    assign wr_acc_s  = run_s && wr_en && !is_zero_reg(wr_addr);
    assign rsv_acc_s = run_s && rsv_en && !is_zero_reg(rsv_addr);
    assign rd_addr_s = {rd_addr_b, rd_addr_a};

    // State register and clear counter; the counter parks at its last entry
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_CLEAR) && (clr_cnt_r != {ADDR_W{1'b1}})) begin
                clr_cnt_r <= clr_cnt_r + 1'b1;
            end
        end
    end

    // Next-state: leave CLEAR once the final entry is being zeroed
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == {ADDR_W{1'b1}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_CLEAR;
        endcase
    end

    // Storage array: sequential zeroing during CLEAR, writeback port during RUN
    always_ff @(posedge clk) begin
        if (Reset) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clr_cnt_r] <= {DATA_W{1'b0}};
            end else if (wr_acc_s) begin
                mem_r[wr_addr] <= wr_data;
            end
        end
    end

    // Scoreboard and orphan flag; the reserve update comes last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (!Reset) begin
            pending_r <= {DEPTH{1'b0}};
            orphan_r  <= 1'b0;
        end else begin
            orphan_r <= wr_acc_s && !pending_r[wr_addr];
            if (wr_acc_s) begin
                pending_r[wr_addr] <= 1'b0;
            end
            if (rsv_acc_s) begin
                pending_r[rsv_addr] <= 1'b1;
            end
        end
    end

    // Read ports with optional same-cycle forwarding of the write data
    always_comb begin
        rd_data_s = {2 * DATA_W{1'b0}};
        busy_s    = 2'b00;
        for (int p = 0; p < 2; p++) begin
            if (!run_s || is_zero_reg(rd_addr_s[p])) begin
                rd_data_s[p] = {DATA_W{1'b0}};
                busy_s[p]    = 1'b0;
            end else if (BYPASS && wr_acc_s && (wr_addr == rd_addr_s[p])) begin
                rd_data_s[p] = wr_data;
                busy_s[p]    = rsv_acc_s && (rsv_addr == rd_addr_s[p]);
            end else begin
                rd_data_s[p] = mem_r[rd_addr_s[p]];
                busy_s[p]    = pending_r[rd_addr_s[p]];
            end
        end
    end

    assign rd_data_a = rd_data_s[0];
    assign rd_data_b = rd_data_s[1];
    assign busy_a    = busy_s[0];
    assign busy_b    = busy_s[1];
    assign ready     = run_s;
    assign wr_orphan = orphan_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vectors, a reference model of the register file rules,
// and a per-cycle compare of every output against that model.
module tb_regfile_mp;

    localparam bit BYPASS = 1'b1;

    logic        clk;
    logic        Reset;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
    logic [31:0] rd_data_a, rd_data_b, wr_data;
    logic        busy_a, busy_b, wr_en, rsv_en, ready, wr_orphan;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Reference model state
    int          m_edges;
    logic [31:0] m_mem [32];
    logic [31:0] m_pend;
    logic        m_orphan;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(BYPASS)) dut (
        .clk(clk), .Reset(Reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .ready(ready), .wr_orphan(wr_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_zero(input logic [4:0] a);
`ifdef REGFILE_ZERO_REG_EN
        return a == 5'd0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: reset zeroes everything; the file is usable once 32 edges have elapsed with reset high
    always @(posedge clk) begin
        if (!Reset) begin
            m_edges  <= 0;
            m_pend   <= 32'h0;
            m_orphan <= 1'b0;
            for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
        end else if (m_edges < 32) begin
            m_edges  <= m_edges + 1;
            m_orphan <= 1'b0;
        end else begin
            m_orphan <= wr_en && !is_zero(wr_addr) && !m_pend[wr_addr];
            if (wr_en && !is_zero(wr_addr)) m_mem[wr_addr] <= wr_data;
            for (int i = 0; i < 32; i++) begin
                if (rsv_en && rsv_addr == 5'(i) && !is_zero(rsv_addr)) m_pend[i] <= 1'b1;
                else if (wr_en && wr_addr == 5'(i) && !is_zero(wr_addr)) m_pend[i] <= 1'b0;
            end
        end
    end

    function automatic void exp_port(input logic [4:0] a, output logic [31:0] d, output logic b);
        if (m_edges < 32 || is_zero(a)) begin
            d = 32'h0; b = 1'b0;
        end else if (BYPASS && wr_en && wr_addr == a) begin
            d = wr_data; b = rsv_en && rsv_addr == a;
        end else begin
            d = m_mem[a]; b = m_pend[a];
        end
    endfunction

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        logic [31:0] ed;
        logic        eb;
        if (checking) begin
            chk("ready", {31'h0, ready}, {31'h0, m_edges >= 32});
            chk("wr_orphan", {31'h0, wr_orphan}, {31'h0, m_orphan});
            exp_port(rd_addr_a, ed, eb);
            chk("rd_data_a", rd_data_a, ed);
            chk("busy_a", {31'h0, busy_a}, {31'h0, eb});
            exp_port(rd_addr_b, ed, eb);
            chk("rd_data_b", rd_data_b, ed);
            chk("busy_b", {31'h0, busy_b}, {31'h0, eb});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int cnt = 0;
        while (!ready && cnt < 40) begin
            tick();
            cnt++;
        end
        chk(name, cnt, 32'd32);
    endtask

    initial begin
        Reset = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0; wr_addr = 5'd0; rsv_addr = 5'd0; wr_data = 32'h0;
        tick();
        checking = 1'b1;
        chk("reset_ready", {31'h0, ready}, 32'h0);
        chk("reset_orphan", {31'h0, wr_orphan}, 32'h0);
        Reset = 1'b1;
        wait_ready("clear_cycles");

        // Every entry cleared
        for (int a = 0; a < 32; a++) begin
            rd_addr_a = 5'(a);
            rd_addr_b = 5'(31 - a);
            #1;
            chk("sweep_data", rd_data_a | rd_data_b, 32'h0);
            chk("sweep_busy", {30'h0, busy_a, busy_b}, 32'h0);
            tick();
        end

        // Write 5 with same-cycle forwarding
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        #1;
        chk("bypass_a", rd_data_a, 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        #1;
        chk("stored_a", rd_data_a, 32'hDEADBEEF);
        chk("stored_b", rd_data_b, 32'hDEADBEEF);
        chk("orphan5", {31'h0, wr_orphan}, 32'h1);

        // Reserve 7, then write it
        rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr_a = 5'd7;
        tick();
        rsv_en = 1'b0;
        #1;
        chk("busy7", {31'h0, busy_a}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000077;
        tick();
        wr_en = 1'b0;
        #1;
        chk("busy7_clr", {31'h0, busy_a}, 32'h0);
        chk("orphan7", {31'h0, wr_orphan}, 32'h0);

        // Unreserved write 8 pulses orphan for one cycle
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h00000088;
        tick();
        wr_en = 1'b0;
        #1;
        chk("orphan8", {31'h0, wr_orphan}, 32'h1);
        tick();
        chk("orphan8_end", {31'h0, wr_orphan}, 32'h0);

        // Same-cycle write and reserve to 9
        wr_en = 1'b1; rsv_en = 1'b1; wr_addr = 5'd9; rsv_addr = 5'd9; wr_data = 32'h00001234;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0; rd_addr_a = 5'd9;
        #1;
        chk("data9", rd_data_a, 32'h00001234);
        chk("busy9", {31'h0, busy_a}, 32'h1);

        // Mixed traffic on both ports
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 5'(16 + i); wr_data = 32'hA5A50000 | i;
            rsv_en = 1'b1; rsv_addr = 5'(24 + i);
            rd_addr_a = 5'(15 + i); rd_addr_b = 5'(23 + i);
            tick();
        end
        wr_en = 1'b1; wr_addr = 5'd24; wr_data = 32'h0BADF00D; rsv_en = 1'b0; rd_addr_a = 5'd24;
        tick();
        wr_en = 1'b0; rd_addr_b = 5'd19;
        #1;
        chk("data19", rd_data_b, 32'hA5A50003);
        chk("data24", rd_data_a, 32'h0BADF00D);
        tick();

        // Reset mid-RUN, then again mid-CLEAR at count 10; writes during CLEAR are ignored
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA5555; rsv_en = 1'b1; rsv_addr = 5'd3;
        repeat (10) tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        wait_ready("reclear_cycles");
        wr_en = 1'b0; rsv_en = 1'b0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd9;
        #1;
        chk("gone5", rd_data_a, 32'h0);
        chk("gone9", rd_data_b, 32'h0);
        rd_addr_a = 5'd3;
        #1;
        chk("gone3", rd_data_a, 32'h0);
        chk("busy3", {31'h0, busy_a}, 32'h0);
        tick();

        // Address 0 write plus reserve
        wr_en = 1'b1; rsv_en = 1'b1; wr_addr = 5'd0; rsv_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr_a = 5'd0;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
`ifdef REGFILE_ZERO_REG_EN
        chk("zero_data", rd_data_a, 32'h0);
        chk("zero_busy", {31'h0, busy_a}, 32'h0);
        chk("zero_orphan", {31'h0, wr_orphan}, 32'h0);
`else
        chk("zero_data", rd_data_a, 32'hFFFFFFFF);
        chk("zero_busy", {31'h0, busy_a}, 32'h1);
        chk("zero_orphan", {31'h0, wr_orphan}, 32'h1);
`endif
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
